// File: rtl/mul_div_seq.sv
// mul_div_seq -- control sequencer for a multi-cycle MUL/DIV on a shared-bus
// datapath. One accepted start runs the sequence:
//    IDLE -> LOAD_Y -> EXEC -> WAIT -> WR_LO -> WR_HI -> DONE -> IDLE
// WAIT gives up after TIMEOUT cycles without alu_done and jumps straight to
// DONE with err set.
//
// Parameters
//    TIMEOUT    maximum number of cycles spent in WAIT before abort
//    OP_MUL     ALU opcode driven for multiply
//    OP_DIV     ALU opcode driven for divide
// Ports
//    clk        clock, all state changes on the rising edge
//    clr        asynchronous active-low reset
//    start      request one sequence (sampled in IDLE only)
//    op         0 = multiply, 1 = divide
//    ra, rb     source register indices
//    alu_done   ALU result valid in Z
//    busy       high in every state except IDLE
//    done       one-cycle completion pulse
//    err        abort flag, held until the next accepted start
//    Rout       one-hot register-to-bus drive (bit n drives Rn)
//    Yin, Zin, alu_start        Y load, Z load and ALU start strobes
//    alu_opcode                 ALU opcode (non-zero only in EXEC/WAIT)
//    ZLowOut, ZHighOut          Z halves onto the bus
//    LOin, HIin                 LO / HI load strobes
module mul_div_seq #(
   parameter int         TIMEOUT = 40,
   parameter logic [4:0] OP_MUL  = 5'b01111,
   parameter logic [4:0] OP_DIV  = 5'b10000
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic        op,
   input  logic [3:0]  ra,
   input  logic [3:0]  rb,
   input  logic        alu_done,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] Rout,
   output logic        Yin,
   output logic        Zin,
   output logic        alu_start,
   output logic [4:0]  alu_opcode,
   output logic        ZLowOut,
   output logic        ZHighOut,
   output logic        LOin,
   output logic        HIin
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_Y = 3'd1,
      EXEC   = 3'd2,
      WAIT   = 3'd3,
      WR_LO  = 3'd4,
      WR_HI  = 3'd5,
      DONE   = 3'd6
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          op_reg, op_next;
   logic [3:0]    ra_reg, ra_next;
   logic [3:0]    rb_reg, rb_next;
   logic          err_reg, err_next;

   // State register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         op_reg    <= 1'b0;
         ra_reg    <= 4'd0;
         rb_reg    <= 4'd0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         op_reg    <= op_next;
         ra_reg    <= ra_next;
         rb_reg    <= rb_next;
         err_reg   <= err_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      op_next    = op_reg;
      ra_next    = ra_reg;
      rb_next    = rb_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               op_next    = op;
               ra_next    = ra;
               rb_next    = rb;
               err_next   = 1'b0;
               state_next = LOAD_Y;
            end
         end
         LOAD_Y: state_next = EXEC;
         EXEC: begin
            // counter starts fresh for every WAIT visit
            cnt_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            // alu_done wins even in the last permitted WAIT cycle
            if (alu_done) begin
               state_next = WR_LO;
            end else if (cnt_reg >= CW'(TIMEOUT - 1)) begin
               cnt_next   = CW'(TIMEOUT);
               err_next   = 1'b1;
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         WR_LO:   state_next = WR_HI;
         WR_HI:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic (Zin is the only Mealy output)
   always_comb begin
      busy       = (state_reg != IDLE);
      done       = 1'b0;
      err        = err_reg;
      Rout       = 16'd0;
      Yin        = 1'b0;
      Zin        = 1'b0;
      alu_start  = 1'b0;
      alu_opcode = 5'd0;
      ZLowOut    = 1'b0;
      ZHighOut   = 1'b0;
      LOin       = 1'b0;
      HIin       = 1'b0;
      case (state_reg)
         LOAD_Y: begin
            Rout = 16'd1 << ra_reg;
            Yin  = 1'b1;
         end
         EXEC: begin
            Rout       = 16'd1 << rb_reg;
            alu_start  = 1'b1;
            alu_opcode = op_reg ? OP_DIV : OP_MUL;
         end
         WAIT: begin
            alu_opcode = op_reg ? OP_DIV : OP_MUL;
            Zin        = alu_done;
         end
         WR_LO: begin
            ZLowOut = 1'b1;
            LOin    = 1'b1;
         end
         WR_HI: begin
            ZHighOut = 1'b1;
            HIin     = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mul_div_seq.sv
// tb_mul_div_seq -- directed and randomized checks of mul_div_seq.
// Each transaction is expanded by the bench into the list of bus cycles it
// should produce (LOAD_Y, EXEC, n WAIT cycles, write-back, DONE) and every
// cycle's full output vector is compared, plus a bus-driver exclusivity check.
module tb_mul_div_seq;

   localparam int         TIMEOUT = 40;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;

   logic        clk      = 1'b0;
   logic        clr      = 1'b0;
   logic        start    = 1'b0;
   logic        op       = 1'b0;
   logic [3:0]  ra       = 4'd0;
   logic [3:0]  rb       = 4'd0;
   logic        alu_done = 1'b0;
   logic        busy, done, err, Yin, Zin, alu_start;
   logic        ZLowOut, ZHighOut, LOin, HIin;
   logic [15:0] Rout;
   logic [4:0]  alu_opcode;
   logic [30:0] obs;

   int   tests = 0;
   int   fails = 0;
   logic exp_err = 1'b0;

   always #5 clk = ~clk;

   mul_div_seq #(.TIMEOUT(TIMEOUT), .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)) dut (
      .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb),
      .alu_done(alu_done), .busy(busy), .done(done), .err(err), .Rout(Rout),
      .Yin(Yin), .Zin(Zin), .alu_start(alu_start), .alu_opcode(alu_opcode),
      .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .LOin(LOin), .HIin(HIin)
   );

   assign obs = {busy, done, err, Rout, Yin, Zin, alu_start, alu_opcode,
                 ZLowOut, ZHighOut, LOin, HIin};

   function automatic logic [30:0] mk(input logic b, input logic d, input logic e,
                                      input logic [15:0] r, input logic y,
                                      input logic z, input logic as,
                                      input logic [4:0] opc, input logic zl,
                                      input logic zh, input logic lo, input logic hi);
      return {b, d, e, r, y, z, as, opc, zl, zh, lo, hi};
   endfunction

   task automatic check(input string tag, input logic [30:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      tests++;
      assert ($countones({Rout, ZLowOut, ZHighOut}) <= 1) else begin
         fails++;
         $error("FAIL %s_bus observed=%0d drivers expected<=1", tag,
                $countones({Rout, ZLowOut, ZHighOut}));
      end
      $display("[TB] %s t=%0t out=%h", tag, $time, obs);
   endtask

   // One clock cycle: inputs change 1 time unit after the rising edge,
   // outputs are checked on the falling edge.
   task automatic step(input logic ad, input logic st, input logic [30:0] exp,
                       input string tag);
      @(posedge clk);
      #1;
      alu_done = ad;
      start    = st;
      @(negedge clk);
      check(tag, exp);
   endtask

   // lat = WAIT cycle (1-based) in which alu_done is raised; 0 or >TIMEOUT
   // means the ALU never answers. hold keeps start high throughout.
   task automatic run_seq(input logic o, input logic [3:0] a, input logic [3:0] b,
                          input int lat, input logic hold, input string tag);
      logic [4:0] opc;
      logic       tmo;
      int         nwait;
      logic       ad;
      opc   = o ? OP_DIV : OP_MUL;
      tmo   = (lat == 0) || (lat > TIMEOUT);
      nwait = tmo ? TIMEOUT : lat;
      op = o; ra = a; rb = b;
      step(1'b0, 1'b1, mk(0,0,exp_err,16'd0,0,0,0,5'd0,0,0,0,0), {tag, "_idle"});
      exp_err = 1'b0;
      step(1'b0, hold, mk(1,0,0,16'd1 << a,1,0,0,5'd0,0,0,0,0), {tag, "_ldy"});
      step(1'b0, hold, mk(1,0,0,16'd1 << b,0,0,1,opc,0,0,0,0), {tag, "_exec"});
      for (int i = 1; i <= nwait; i++) begin
         ad = !tmo && (i == lat);
         step(ad, hold, mk(1,0,0,16'd0,0,ad,0,opc,0,0,0,0),
              $sformatf("%s_wait%0d", tag, i));
      end
      if (!tmo) begin
         step(1'b0, hold, mk(1,0,0,16'd0,0,0,0,5'd0,1,0,1,0), {tag, "_wrlo"});
         step(1'b0, hold, mk(1,0,0,16'd0,0,0,0,5'd0,0,1,0,1), {tag, "_wrhi"});
      end else begin
         exp_err = 1'b1;
      end
      step(1'b0, hold, mk(1,1,exp_err,16'd0,0,0,0,5'd0,0,0,0,0), {tag, "_done"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state, before any clock edge
      #3;
      check("reset", mk(0,0,0,16'd0,0,0,0,5'd0,0,0,0,0));
      @(negedge clk);
      clr = 1'b1;
      step(1'b0, 1'b0, mk(0,0,0,16'd0,0,0,0,5'd0,0,0,0,0), "idle0");
      step(1'b1, 1'b0, mk(0,0,0,16'd0,0,0,0,5'd0,0,0,0,0), "idle1");

      // minimum latency multiply
      run_seq(1'b0, 4'd2, 4'd3, 1, 1'b0, "min");
      // divide, ra == rb, answer in the 10th WAIT cycle
      run_seq(1'b1, 4'd5, 4'd5, 10, 1'b0, "div10");
      // ALU never answers: timeout, err sticks, next start clears it
      run_seq(1'b0, 4'd1, 4'd4, 0, 1'b0, "tmo");
      step(1'b1, 1'b0, mk(0,0,1,16'd0,0,0,0,5'd0,0,0,0,0), "tmo_hold0");
      step(1'b0, 1'b0, mk(0,0,1,16'd0,0,0,0,5'd0,0,0,0,0), "tmo_hold1");
      run_seq(1'b0, 4'd6, 4'd6, 1, 1'b0, "after_tmo");
      // answer in the last permitted WAIT cycle, and one before
      run_seq(1'b1, 4'd15, 4'd0, TIMEOUT, 1'b0, "lat_max");
      run_seq(1'b0, 4'd0, 4'd15, TIMEOUT - 1, 1'b0, "lat_max_m1");

      // start held for 20 cycles: exactly two back-to-back sequences
      run_seq(1'b0, 4'd3, 4'd12, 4, 1'b1, "hold1");
      run_seq(1'b1, 4'd12, 4'd3, 4, 1'b1, "hold2");
      step(1'b0, 1'b0, mk(0,0,0,16'd0,0,0,0,5'd0,0,0,0,0), "hold_end0");
      step(1'b0, 1'b0, mk(0,0,0,16'd0,0,0,0,5'd0,0,0,0,0), "hold_end1");

      // asynchronous reset in the middle of WAIT
      op = 1'b1; ra = 4'd7; rb = 4'd9;
      step(1'b0, 1'b1, mk(0,0,0,16'd0,0,0,0,5'd0,0,0,0,0), "rst_idle");
      step(1'b0, 1'b0, mk(1,0,0,16'h0080,1,0,0,5'd0,0,0,0,0), "rst_ldy");
      step(1'b0, 1'b0, mk(1,0,0,16'h0200,0,0,1,OP_DIV,0,0,0,0), "rst_exec");
      for (int i = 1; i <= 3; i++)
         step(1'b0, 1'b0, mk(1,0,0,16'd0,0,0,0,OP_DIV,0,0,0,0),
              $sformatf("rst_wait%0d", i));
      #2;
      clr = 1'b0;
      #1;
      check("rst_async", mk(0,0,0,16'd0,0,0,0,5'd0,0,0,0,0));
      @(posedge clk);
      #1;
      clr = 1'b1;
      exp_err = 1'b0;
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, mk(0,0,0,16'd0,0,0,0,5'd0,0,0,0,0),
              $sformatf("post_rst%0d", i));
      step(1'b0, 1'b0, mk(0,0,0,16'd0,0,0,0,5'd0,0,0,0,0), "post_rst3");

      // randomized transactions
      for (int n = 0; n < 24; n++) begin
         logic       ro;
         logic [3:0] rra, rrb;
         int         rlat;
         ro   = 1'($urandom_range(0, 1));
         rra  = 4'($urandom_range(0, 15));
         rrb  = 4'($urandom_range(0, 15));
         rlat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
         run_seq(ro, rra, rrb, rlat, 1'($urandom_range(0, 1)),
                 $sformatf("rnd%0d", n));
      end
      step(1'b0, 1'b0, mk(0,0,exp_err,16'd0,0,0,0,5'd0,0,0,0,0), "final_idle");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
